counter_seq_ctrl: RTL
=====================

# counter_seq_ctrl

Sequencer for the 8-bit up/down counter. It accepts a command (start value, end value, direction, repeat count) over a valid/ready handshake, then drives the counter's enable/set/up controls until the counter reaches the end value. It repeats that pass the requested number of times, then pulses done. It sits between a host/CSR master and one counter instance, and observes the counter through its registered output.

## Interface
- `WIDTH`, default 8: counter data width.
- `REP_W`, default 4: repeat-count width.

Ports:
- `clk_in`  in  1  — single clock; all logic is on its rising edge.
- `rst_in`  in  1  — reset, synchronous, active-high.
- `cmd_valid_in`  in  1  — command present.
- `cmd_ready_out`  out  1  — command accepted this cycle if `cmd_valid_in` is also high.
- `cmd_start_in`  in  WIDTH  — value loaded at the start of each pass.
- `cmd_end_in`  in  WIDTH  — terminal value.
- `cmd_up_in`  in  1  — 1 = count up, 0 = count down.
- `cmd_reps_in`  in  REP_W  — number of extra passes; total passes = reps + 1.
- `abort_in`  in  1  — cancel the current command.
- `cnt_val_in`  in  WIDTH  — the counter's current registered value.
- `cnt_en_out`  out  1  — counter enable.
- `cnt_set_out`  out  1  — counter load strobe.
- `cnt_up_out`  out  1  — counter direction.
- `cnt_load_out`  out  WIDTH  — counter load value.
- `busy_out`  out  1  — high whenever state ≠ IDLE.
- `done_out`  out  1  — 1-cycle pulse at normal completion.
- `pass_out`  out  REP_W  — index of the current pass, starting at 0.

## Operation
- States: IDLE, LOAD, RUN, DONE.
- **IDLE**
  - `cmd_ready_out` = `!rst_in`.
  - On handshake, latch start, end, up and reps; clear the pass index; go to LOAD.
- **LOAD** (one cycle)
  - Drive `cnt_en_out`=1, `cnt_set_out`=1, `cnt_load_out`=start_q. The counter takes start_q at this edge.
  - Go to RUN.
- **RUN**
  - `cnt_set_out`=0 and `cnt_up_out`=up_q.
  - `cnt_en_out` = (`cnt_val_in` ≠ end_q), combinational. The counter never steps past end_q.
  - When `cnt_val_in` == end_q:
    - if pass == reps_q, go to DONE;
    - otherwise increment pass and go to LOAD.
- **DONE**: `done_out`=1 for one cycle, then go to IDLE.
- **Arithmetic**
  - Counting is modulo 2^WIDTH. Start 0xF0 with end 0x10 counting up passes through 0xFF→0x00.
  - Steps per pass = (end − start) mod 256 when up; (start − end) mod 256 when down.
- **Abort**
  - `abort_in` in LOAD or RUN: next state IDLE, no `done_out`.
  - `cnt_en_out` is forced 0 in the abort cycle, so the counter holds its value.
  - `abort_in` is ignored in IDLE and DONE.
- **Other rules**
  - A new command is accepted only in IDLE. `cmd_valid_in` held during busy is not consumed.
  - `cnt_up_out`, `cnt_load_out` and `cnt_set_out` are don't-care when `cnt_en_out`=0, but are driven 0 in IDLE.
- **Reset values**
  - State IDLE; all outputs 0; pass 0; latched fields 0.
  - `rst_in` mid-command returns to IDLE in the next cycle with no `done_out`. The counter's contents are left untouched.

## Timing
- Handshake at edge E0. LOAD occupies cycle E0→E1. The counter holds start from E1. RUN begins at E1.
- A pass of N steps occupies 1 (LOAD) + N (stepping) + 1 (terminal detect) cycles.
- start == end gives N=0: 2 cycles per pass.
- `done_out` is asserted in the cycle after the terminal detect of the final pass.
- `cmd_ready_out` is high again the cycle after DONE.
- The latency from handshake to `done_out` is Σ over passes of (N+2), plus 1.
- The counter's `ovf_out` is not used.

## Structure
- Shared package `counter_pkg` holds:
  - the state enum (IDLE/LOAD/RUN/DONE);
  - the `WIDTH` and `REP_W` default constants;
  - a command struct {start, end, up, reps}.
- One natural sub-module, `counter_seq_reps`: the pass counter with load, increment and compare-to-reps (it drives `pass_out`).
- The FSM and output decode stay in `counter_seq_ctrl`. The controlled counter is instantiated beside it, not inside it.

## Test plan
- Reset held 3 cycles, then released → all outputs 0, `cmd_ready_out`=1 on the first cycle after release.
- Command start=0x05, end=0x08, up, reps=0 → one LOAD cycle with load=0x05; counter reads 05,06,07,08; `en` drops at 08; `done_out` 5 cycles after LOAD begins.
- Command start=0xFE, end=0x01, up, reps=1 → counter wraps FE,FF,00,01 twice; `pass_out` reads 0 then 1; exactly one `done_out`.
- Command start=0x03, end=0x03, down, reps=2 → three 2-cycle passes, counter fixed at 0x03, `done_out` after 7 cycles.
- Command start=0x10, end=0x00, down; `abort_in` asserted when the counter reads 0x0C → `cnt_en_out`=0 that cycle, counter holds 0x0C, IDLE next cycle, no `done_out`.
- `cmd_valid_in` held high during busy, plus `rst_in` pulsed mid-RUN → second command not accepted while busy; after reset, FSM in IDLE and the held command is accepted on the next cycle.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared types and default widths for the counter sequencer and its pass counter.
package counter_pkg;

    localparam int WIDTH_DEF = 8;
    localparam int REP_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] start_val;
        logic [WIDTH_DEF-1:0] end_val;
        logic                 up;
        logic [REP_W_DEF-1:0] reps;
    } seq_cmd_t;

endpackage

// File: rtl/counter_seq_reps.sv
// Pass counter: holds the requested repeat count, tracks the current pass index
// and flags when the current pass is the final one.
module counter_seq_reps
    import counter_pkg::*;
#(
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             load_in,
    input  logic [REP_W-1:0] reps_in,
    input  logic             inc_in,
    output logic [REP_W-1:0] pass_out,
    output logic             last_out
);

    logic [REP_W-1:0] reps_q, reps_d;
    logic [REP_W-1:0] pass_q, pass_d;

    always_comb begin
        reps_d = reps_q;
        pass_d = pass_q;
        if (load_in) begin
            reps_d = reps_in;
            pass_d = '0;
        end else if (inc_in) begin
            pass_d = pass_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            reps_q <= '0;
            pass_q <= '0;
        end else begin
            reps_q <= reps_d;
            pass_q <= pass_d;
        end
    end

    assign pass_out = pass_q;
    assign last_out = (pass_q == reps_q);

endmodule

// File: rtl/counter_seq_ctrl.sv
// Sequencer for an external up/down counter: loads the start value, lets the
// counter run to the end value, repeats for the requested passes, then pulses done.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int REP_W = REP_W_DEF
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             cmd_valid_in,
    output logic             cmd_ready_out,
    input  logic [WIDTH-1:0] cmd_start_in,
    input  logic [WIDTH-1:0] cmd_end_in,
    input  logic             cmd_up_in,
    input  logic [REP_W-1:0] cmd_reps_in,
    input  logic             abort_in,
    input  logic [WIDTH-1:0] cnt_val_in,
    output logic             cnt_en_out,
    output logic             cnt_set_out,
    output logic             cnt_up_out,
    output logic [WIDTH-1:0] cnt_load_out,
    output logic             busy_out,
    output logic             done_out,
    output logic [REP_W-1:0] pass_out
);

    seq_state_e       state_q, state_d;
    logic [WIDTH-1:0] start_q, start_d;
    logic [WIDTH-1:0] end_q, end_d;
    logic             up_q, up_d;
    logic             accept;
    logic             pass_inc;
    logic             pass_last;
    logic [REP_W-1:0] pass_val;

    counter_seq_reps #(.REP_W(REP_W)) u_reps (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .load_in  (accept),
        .reps_in  (cmd_reps_in),
        .inc_in   (pass_inc),
        .pass_out (pass_val),
        .last_out (pass_last)
    );

    always_comb begin
        state_d       = state_q;
        start_d       = start_q;
        end_d         = end_q;
        up_d          = up_q;
        accept        = 1'b0;
        pass_inc      = 1'b0;
        cmd_ready_out = 1'b0;
        cnt_en_out    = 1'b0;
        cnt_set_out   = 1'b0;
        cnt_up_out    = 1'b0;
        cnt_load_out  = '0;
        done_out      = 1'b0;
        busy_out      = (state_q != ST_IDLE);

        unique case (state_q)
            ST_IDLE: begin
                cmd_ready_out = 1'b1;
                if (cmd_valid_in) begin
                    accept  = 1'b1;
                    start_d = cmd_start_in;
                    end_d   = cmd_end_in;
                    up_d    = cmd_up_in;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_en_out   = 1'b1;
                    cnt_set_out  = 1'b1;
                    cnt_up_out   = up_q;
                    cnt_load_out = start_q;
                    state_d      = ST_RUN;
                end
            end
            ST_RUN: begin
                cnt_up_out = up_q;
                if (abort_in) begin
                    state_d = ST_IDLE;
                end else if (cnt_val_in == end_q) begin
                    if (pass_last) begin
                        state_d = ST_DONE;
                    end else begin
                        pass_inc = 1'b1;
                        state_d  = ST_LOAD;
                    end
                end else begin
                    cnt_en_out = 1'b1;
                end
            end
            ST_DONE: begin
                done_out = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset silences every output so the counter keeps its contents.
        if (rst_in) begin
            accept        = 1'b0;
            pass_inc      = 1'b0;
            cmd_ready_out = 1'b0;
            cnt_en_out    = 1'b0;
            cnt_set_out   = 1'b0;
            cnt_up_out    = 1'b0;
            cnt_load_out  = '0;
            done_out      = 1'b0;
            busy_out      = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q <= ST_IDLE;
            start_q <= '0;
            end_q   <= '0;
            up_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            end_q   <= end_d;
            up_q    <= up_d;
        end
    end

    assign pass_out = rst_in ? '0 : pass_val;

endmodule
